// File: rtl/fb_pkg.sv
// Shared types and helpers for the double-buffered frame-buffer controller:
// FSM state encoding, geometry derivation and RGB222 -> RGB565 expansion.
package fb_pkg;

  typedef enum logic [1:0] {
    WRITE = 2'd0,
    FULL  = 2'd1,
    CLEAR = 2'd2
  } fb_state_e;

  function automatic int fb_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int fb_dim(input int active, input int scale_log2);
    return active >> scale_log2;
  endfunction

  function automatic int fb_bank_aw(input int h_active, input int v_active, input int scale_log2);
    return fb_clog2(fb_dim(h_active, scale_log2) * fb_dim(v_active, scale_log2));
  endfunction

  // Bit replication keeps full-scale 2'b11 mapping to full-scale 5/6-bit values.
  function automatic logic [15:0] rgb222_to_565(input logic [5:0] p);
    return {p[5:4], p[5:4], p[5], p[3:2], p[3:2], p[3:2], p[1:0], p[1:0], p[1]};
  endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM holding both banks: port A writes, port B reads
// through one output register.
module fb_dpram
  import fb_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rdata_q <= '0;
    else       rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/fb_ctl_dbuf.sv
// Double-buffered frame-buffer controller: the generator fills the back bank,
// the display scans the front bank upscaled, banks swap on vsync after i_done.
module fb_ctl_dbuf
  import fb_pkg::*;
#(
  parameter int              H_ACTIVE   = 1600,
  parameter int              V_ACTIVE   = 900,
  parameter int              SCALE_LOG2 = 2,
  parameter int              PIX_W      = 6,
  parameter logic [PIX_W-1:0] CLEAR_VAL = '0
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst,
  input  logic                                             i_vsync,
  input  logic                                             i_enc,
  output logic [15:0]                                      o_data,
  output logic                                             o_de,
  input  logic                                             i_wr_valid,
  output logic                                             o_wr_ready,
  input  logic [fb_clog2(fb_dim(H_ACTIVE, SCALE_LOG2))-1:0] i_x,
  input  logic [fb_clog2(fb_dim(V_ACTIVE, SCALE_LOG2))-1:0] i_y,
  input  logic [PIX_W-1:0]                                 i_data,
  input  logic                                             i_done,
  input  logic                                             i_clear,
  output logic                                             o_rdy,
  output logic                                             o_drop
);

  localparam int FB_W    = fb_dim(H_ACTIVE, SCALE_LOG2);
  localparam int FB_H    = fb_dim(V_ACTIVE, SCALE_LOG2);
  localparam int FB_N    = FB_W * FB_H;
  localparam int BANK_AW = fb_bank_aw(H_ACTIVE, V_ACTIVE, SCALE_LOG2);
  localparam int HW      = fb_clog2(H_ACTIVE);
  localparam int VW      = fb_clog2(V_ACTIVE);
  localparam logic [BANK_AW-1:0] FB_W_A = BANK_AW'(FB_W);
  localparam logic [BANK_AW-1:0] LAST_A = BANK_AW'(FB_N - 1);

  fb_state_e state_q, state_d;
  logic front_q, front_d;
  logic rd_bank_q, rd_bank_d;
  logic vsync_q;
  logic rdy_q, rdy_d;
  logic drop_q, drop_d;
  logic [BANK_AW-1:0] clr_q, clr_d;
  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic [BANK_AW:0] rd_addr_q, rd_addr_d;
  logic de1_q, de2_q;

  logic in_range, wr_acc, vs_rise, ram_we;
  logic [BANK_AW-1:0] wr_off, rd_off;
  logic [BANK_AW:0] ram_waddr;
  logic [PIX_W-1:0] ram_wdata, ram_rdata;

  always_comb begin
    in_range = (32'(i_x) < FB_W) && (32'(i_y) < FB_H);
    wr_acc   = (state_q == WRITE) && i_wr_valid;
    wr_off   = BANK_AW'(i_y) * FB_W_A + BANK_AW'(i_x);
    vs_rise  = i_vsync && !vsync_q;

    state_d   = state_q;
    front_d   = front_q;
    clr_d     = clr_q;
    drop_d    = wr_acc && !in_range;
    ram_we    = 1'b0;
    ram_waddr = {~front_q, wr_off};
    ram_wdata = i_data;

    case (state_q)
      WRITE: begin
        ram_we = wr_acc && in_range;
        if (i_clear) begin
          state_d = CLEAR;
          clr_d   = '0;
        end else if (i_done) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (i_clear) begin
          state_d = CLEAR;
          clr_d   = '0;
        end else if (vs_rise) begin
          front_d = ~front_q;
          state_d = WRITE;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = {~front_q, clr_q};
        ram_wdata = CLEAR_VAL;
        clr_d     = clr_q + 1'b1;
        if (clr_q == LAST_A) begin
          state_d = WRITE;
          clr_d   = '0;
        end
      end
      default: state_d = WRITE;
    endcase

    rdy_d = (state_d == WRITE);

    // Sampling front_d lets even a one-cycle vsync pick up the swap it caused.
    rd_bank_d = i_vsync ? front_d : rd_bank_q;

    x_d = x_q;
    y_d = y_q;
    if (i_vsync) begin
      x_d = '0;
      y_d = '0;
    end else if (i_enc) begin
      if (x_q == HW'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = (y_q == VW'(V_ACTIVE - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    rd_off    = BANK_AW'(y_q >> SCALE_LOG2) * FB_W_A + BANK_AW'(x_q >> SCALE_LOG2);
    rd_addr_d = {rd_bank_q, rd_off};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= WRITE;
      front_q   <= 1'b0;
      rd_bank_q <= 1'b0;
      vsync_q   <= 1'b0;
      rdy_q     <= 1'b1;
      drop_q    <= 1'b0;
      clr_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rd_addr_q <= '0;
      de1_q     <= 1'b0;
      de2_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      rd_bank_q <= rd_bank_d;
      vsync_q   <= i_vsync;
      rdy_q     <= rdy_d;
      drop_q    <= drop_d;
      clr_q     <= clr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rd_addr_q <= rd_addr_d;
      de1_q     <= i_enc;
      de2_q     <= de1_q;
    end
  end

  fb_dpram #(
    .AW(BANK_AW + 1),
    .DW(PIX_W)
  ) u_ram (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (ram_we),
    .i_waddr(ram_waddr),
    .i_wdata(ram_wdata),
    .i_raddr(rd_addr_q),
    .o_rdata(ram_rdata)
  );

  generate
    if (PIX_W == 6) begin : g_rgb222
      assign o_data = rgb222_to_565(ram_rdata);
    end else begin : g_rgb565
      assign o_data = 16'(ram_rdata);
    end
  endgenerate

  assign o_de       = de2_q;
  assign o_rdy      = rdy_q;
  assign o_wr_ready = rdy_q;
  assign o_drop     = drop_q;

endmodule

// File: tb/tb_fb_ctl_dbuf.sv
// Scoreboard bench for fb_ctl_dbuf on a reduced 40x24 screen (10x6 stored
// pixels) so that clears and full display frames stay short.
module tb_fb_ctl_dbuf;

  localparam int H_ACT = 40;
  localparam int V_ACT = 24;
  localparam int FB_W  = 10;
  localparam int FB_N  = 60;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_vsync = 1'b0;
  logic        i_enc = 1'b0;
  logic [15:0] o_data;
  logic        o_de;
  logic        i_wr_valid = 1'b0;
  logic        o_wr_ready;
  logic [3:0]  i_x = '0;
  logic [2:0]  i_y = '0;
  logic [5:0]  i_data = '0;
  logic        i_done = 1'b0;
  logic        i_clear = 1'b0;
  logic        o_rdy;
  logic        o_drop;

  typedef struct {
    logic [15:0] v;
    int          x;
    int          y;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] img [FB_N];
  int          n_checks = 0;
  int          n_pass = 0;

  fb_ctl_dbuf #(
    .H_ACTIVE  (H_ACT),
    .V_ACTIVE  (V_ACT),
    .SCALE_LOG2(2),
    .PIX_W     (6),
    .CLEAR_VAL (6'd0)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_vsync   (i_vsync),
    .i_enc     (i_enc),
    .o_data    (o_data),
    .o_de      (o_de),
    .i_wr_valid(i_wr_valid),
    .o_wr_ready(o_wr_ready),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_data    (i_data),
    .i_done    (i_done),
    .i_clear   (i_clear),
    .o_rdy     (o_rdy),
    .o_drop    (o_drop)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s got %h want %h", name, got, want);
  endtask

  // One write-side cycle; everything returns to idle after the edge.
  task automatic applyStimulus(input logic valid, input logic [3:0] x, input logic [2:0] y,
                               input logic [5:0] d, input logic done, input logic clear);
    i_wr_valid = valid;
    i_x        = x;
    i_y        = y;
    i_data     = d;
    i_done     = done;
    i_clear    = clear;
    tick();
    i_wr_valid = 1'b0;
    i_done     = 1'b0;
    i_clear    = 1'b0;
  endtask

  task automatic vsyncPulse();
    i_vsync = 1'b1;
    tick();
    tick();
    i_vsync = 1'b0;
    tick();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rdy"}, 16'(o_rdy), 16'd1);
    checkOutput({tag, "_wr_ready"}, 16'(o_wr_ready), 16'd1);
    checkOutput({tag, "_drop"}, 16'(o_drop), 16'd0);
    checkOutput({tag, "_de"}, 16'(o_de), 16'd0);
    checkOutput({tag, "_data"}, o_data, 16'h0000);
  endtask

  task automatic clearBank(input string tag);
    int cnt;
    applyStimulus(1'b0, 4'd0, 3'd0, 6'd0, 1'b0, 1'b1);
    checkOutput({tag, "_busy"}, 16'(o_rdy), 16'd0);
    cnt = 0;
    while (!o_rdy && cnt < 200) begin
      tick();
      cnt++;
    end
    checkOutput({tag, "_len"}, 16'(cnt), 16'(FB_N));
  endtask

  task automatic swapBanks(input string tag);
    applyStimulus(1'b0, 4'd0, 3'd0, 6'd0, 1'b1, 1'b0);
    checkOutput({tag, "_full"}, 16'(o_wr_ready), 16'd0);
    vsyncPulse();
    checkOutput({tag, "_write"}, 16'(o_rdy), 16'd1);
  endtask

  task automatic runFrame(input string tag);
    exp_t e;
    for (int yy = 0; yy < V_ACT; yy++) begin
      for (int xx = 0; xx < H_ACT; xx++) begin
        i_enc = 1'b1;
        e.v = img[(yy >> 2) * FB_W + (xx >> 2)];
        e.x = xx;
        e.y = yy;
        exp_q.push_back(e);
        tick();
      end
    end
    i_enc = 1'b0;
    repeat (4) tick();
    checkOutput({tag, "_drained"}, 16'(exp_q.size()), 16'd0);
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst && o_de) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_de got %h want no pixel", o_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("pix_x%0d_y%0d", e.x, e.y), o_data, e.v);
      end
    end
  end

  initial begin
    int cnt;
    foreach (img[i]) img[i] = 16'h0000;

    repeat (2) tick();
    i_rst = 1'b0;
    tick();
    checkReset("reset");

    $display("[TB] clear both banks, show blank frame");
    clearBank("clr1");
    swapBanks("swap0");
    clearBank("clr0");
    runFrame("blank");

    $display("[TB] single pixel image and out-of-range drops");
    applyStimulus(1'b1, 4'd10, 3'd0, 6'b111111, 1'b0, 1'b0);
    checkOutput("drop_x_pulse", 16'(o_drop), 16'd1);
    applyStimulus(1'b1, 4'd3, 3'd6, 6'b111111, 1'b0, 1'b0);
    checkOutput("drop_y_pulse", 16'(o_drop), 16'd1);
    tick();
    checkOutput("drop_clear", 16'(o_drop), 16'd0);
    applyStimulus(1'b1, 4'd3, 3'd2, 6'b110110, 1'b0, 1'b0);
    checkOutput("inrange_nodrop", 16'(o_drop), 16'd0);
    swapBanks("swapA");
    img[23] = 16'hFAB5;
    runFrame("imgA");

    $display("[TB] write with done, blocked write in FULL");
    applyStimulus(1'b1, 4'd0, 3'd0, 6'b001011, 1'b1, 1'b0);
    i_wr_valid = 1'b1;
    i_x        = 4'd1;
    i_y        = 3'd0;
    i_data     = 6'b110110;
    checkOutput("full_wr_ready", 16'(o_wr_ready), 16'd0);
    checkOutput("full_rdy", 16'(o_rdy), 16'd0);
    tick();
    i_wr_valid = 1'b0;
    runFrame("imgA_hold");
    vsyncPulse();
    checkOutput("swapB_write", 16'(o_rdy), 16'd1);
    foreach (img[i]) img[i] = 16'h0000;
    img[0] = 16'h055F;
    runFrame("imgB");

    $display("[TB] done and clear together, vsync during clear");
    applyStimulus(1'b0, 4'd0, 3'd0, 6'd0, 1'b1, 1'b1);
    checkOutput("both_clear", 16'(o_rdy), 16'd0);
    repeat (5) tick();
    vsyncPulse();
    checkOutput("clear_vsync_busy", 16'(o_rdy), 16'd0);
    cnt = 0;
    while (!o_rdy && cnt < 200) begin
      tick();
      cnt++;
    end
    checkOutput("both_clear_done", 16'(o_rdy), 16'd1);
    runFrame("imgB_kept");

    $display("[TB] reset in the middle of a clear");
    applyStimulus(1'b0, 4'd0, 3'd0, 6'd0, 1'b0, 1'b1);
    repeat (20) tick();
    checkOutput("midclr_busy", 16'(o_rdy), 16'd0);
    i_rst = 1'b1;
    #2;
    checkReset("midclr_rst");
    tick();
    i_rst = 1'b0;
    tick();
    applyStimulus(1'b1, 4'd9, 3'd5, 6'b001011, 1'b0, 1'b0);
    swapBanks("swapC");
    img[59] = 16'h055F;
    runFrame("imgC");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
